mode_menu_text_ctrl: RTL and testbench
======================================

Name: mode_menu_text_ctrl

Overview:
Sequencer and controller for the mode-select text overlay. Scans the 16x4 character text window in step with the VGA pixel coordinates and drives the text ROM address (char_xy). Pipelines the returned char_code through the synchronous 8x16 font ROM to produce a text pixel. Runs the menu FSM (cursor, blink highlight, selection) that reports the chosen game mode to the top-level game controller.

Parameters:
TEXT_X0, 256, left pixel column of the text window (multiple of 8)
TEXT_Y0, 208, top pixel row of the text window (multiple of 16)
NUM_MODES, 3, selectable option rows; text rows 1..NUM_MODES; 1..3
BLINK_BITS, 24, blink counter width; highlight phase = counter MSB

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pixel_x  in  10  current pixel column from vga_sync
pixel_y  in  10  current pixel row from vga_sync
video_on  in  1  active display area
menu_active  in  1  level; game controller requests the menu
btn_up  in  1  single-cycle debounced pulse
btn_down  in  1  single-cycle debounced pulse
btn_sel  in  1  single-cycle debounced pulse
char_xy  out  8  text ROM address {row[3:0], col[3:0]}
char_code  in  7  combinational text ROM data (ASCII)
font_addr  out  11  font ROM address {char_code, glyph_row[3:0]}
font_word  in  8  font ROM data, valid 1 clk after font_addr
text_on  out  1  pixel lies in the text window while the menu is shown
text_bit  out  1  glyph pixel, reverse-video on highlighted row
mode  out  2  last confirmed mode index
mode_valid  out  1  one-clock pulse when mode is updated

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FSM=IDLE; cursor=0; blink=0; pipeline cleared.
- Window hit: in_win = video_on && TEXT_X0<=pixel_x<TEXT_X0+128 && TEXT_Y0<=pixel_y<TEXT_Y0+64. col=(pixel_x-TEXT_X0)>>3, row=(pixel_y-TEXT_Y0)>>4, gly_row=(pixel_y-TEXT_Y0)[3:0], bit_idx=(pixel_x-TEXT_X0)[2:0]. All arithmetic is 10-bit unsigned and truncated.
- Pipeline stages advance every clk with no stall:
  - S1: char_xy<={row,col}; register in_win, gly_row, bit_idx, row.
  - S2: font_addr<={char_code,gly_row_s1}; delay the sideband.
  - S3: font_word valid; text_bit<=font_word[7-bit_idx_s2] ^ hl_s2; text_on<=in_win_s2 && show_s2.
- Latency: exactly 3 clk from pixel_x/pixel_y to text_on/text_bit. vga_sync delays its hsync/vsync by 3 clk to stay aligned.
- Outside the window: char_xy=8'h00, text_on=0, text_bit=0.
- hl = (row==cursor+1) && blink[BLINK_BITS-1] && state==MENU. Row 0 (the title) is never highlighted.
- FSM:
  - IDLE: show=0. menu_active=1 -> MENU, with cursor=0 and blink=0.
  - MENU: show=1; blink increments every clk and wraps.
    - btn_down only: cursor=cursor+1, wrapping NUM_MODES-1 -> 0.
    - btn_up only: cursor=cursor-1, wrapping 0 -> NUM_MODES-1.
    - btn_up and btn_down in the same clk: no change.
    - btn_sel: -> CONFIRM. btn_sel takes priority over up/down in the same clk, and the cursor is not moved.
    - menu_active=0 while in MENU: -> IDLE with no mode update.
  - CONFIRM (1 clk): show=1; mode<=cursor; mode_valid=1; -> DONE.
  - DONE: show=0; buttons ignored; menu_active=0 -> IDLE.
- mode holds its value across menu sessions until the next CONFIRM.
- A reset mid-frame or mid-menu returns the block to IDLE immediately. The pipeline outputs 0 until 3 valid clocks have elapsed.

Decomposition:
- Shared package pong_pkg: TEXT_COLS=16, TEXT_ROWS=4, FONT_W=8, FONT_H=16, the FSM state encoding (IDLE, MENU, CONFIRM, DONE), and the mode index constants.
- One sub-module, text_scan_pipe: window decode plus the 3-stage address/font pipeline, taking hl/show as sideband inputs.
- The menu FSM, cursor and blink logic stay in the top module.

Test Plan:
1. Reset with menu_active=0 -> all outputs 0. Sweep a frame -> text_on stays 0.
2. menu_active=1; pixel=(256,208) -> char_xy=8'h00 one clk later. With stub ROM 'M' (7'h4D), font_addr=11'h4D0 at clk+2. With font_word=8'h80, text_on=1 and text_bit=1 at clk+3.
3. Pixel (383,271) -> char_xy=8'h3F. Pixel (384,208) -> text_on=0 three clocks later.
4. In MENU, with cursor=0: btn_up -> cursor=2; btn_down x2 -> cursor=1; up and down in the same clk -> cursor stays 1.
5. cursor=1 then btn_sel -> mode=1 and mode_valid=1 for exactly 1 clk. Buttons in DONE are ignored. menu_active low -> IDLE; high again -> cursor=0.
6. Force blink MSB=1 with cursor=0 -> bits on row 1 are inverted and row 0 is not. Assert reset_n=0 mid-MENU -> FSM=IDLE and outputs 0 asynchronously; mode is cleared to 0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants for the mode-select text overlay: text window geometry,
// menu FSM state encoding and game mode indices.
package pong_pkg;

  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 4;
  localparam int FONT_W    = 8;
  localparam int FONT_H    = 16;
  localparam int WIN_W     = TEXT_COLS * FONT_W;
  localparam int WIN_H     = TEXT_ROWS * FONT_H;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MENU    = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_DONE    = 2'd3
  } menu_state_e;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;

endpackage

// File: rtl/text_scan_pipe.sv
// Text window decode and 3-stage text ROM / font ROM pipeline producing the
// overlay pixel; highlight and show arrive as sideband alongside the pixel.
module text_scan_pipe
  import pong_pkg::*;
#(
  parameter int TEXT_X0 = 256,
  parameter int TEXT_Y0 = 208
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        show,
  input  logic        hl,
  input  logic [6:0]  char_code,
  input  logic [7:0]  font_word,
  output logic [3:0]  win_row,
  output logic [7:0]  char_xy,
  output logic [10:0] font_addr,
  output logic        text_on,
  output logic        text_bit
);

  localparam logic [9:0] X0 = 10'(TEXT_X0);
  localparam logic [9:0] Y0 = 10'(TEXT_Y0);

  logic [9:0] dx, dy;
  logic       in_win;

  logic [7:0]  char_xy_q, char_xy_d;
  logic        in_win_s1_q, in_win_s1_d;
  logic [3:0]  gly_row_s1_q, gly_row_s1_d;
  logic [2:0]  bit_idx_s1_q, bit_idx_s1_d;
  logic        hl_s1_q, hl_s1_d;
  logic        show_s1_q, show_s1_d;

  logic [10:0] font_addr_q, font_addr_d;
  logic        in_win_s2_q, in_win_s2_d;
  logic [2:0]  bit_idx_s2_q, bit_idx_s2_d;
  logic        hl_s2_q, hl_s2_d;
  logic        show_s2_q, show_s2_d;

  logic        text_on_q, text_on_d;
  logic        text_bit_q, text_bit_d;

  // Once pixel >= origin the offset cannot wrap, so the upper offset bits
  // being zero is exactly the "< origin + size" test.
  always_comb begin
    dx      = pixel_x - X0;
    dy      = pixel_y - Y0;
    in_win  = video_on && (pixel_x >= X0) && (dx[9:7] == 3'd0) &&
              (pixel_y >= Y0) && (dy[9:6] == 4'd0);
    win_row = in_win ? dy[7:4] : 4'd0;
  end

  always_comb begin
    // S1: text ROM address and sideband capture
    char_xy_d    = in_win ? {dy[7:4], dx[6:3]} : 8'h00;
    in_win_s1_d  = in_win;
    gly_row_s1_d = in_win ? dy[3:0] : 4'd0;
    bit_idx_s1_d = in_win ? dx[2:0] : 3'd0;
    hl_s1_d      = in_win && hl;
    show_s1_d    = show;
    // S2: font ROM address from the returned character code
    font_addr_d  = {char_code, gly_row_s1_q};
    in_win_s2_d  = in_win_s1_q;
    bit_idx_s2_d = bit_idx_s1_q;
    hl_s2_d      = hl_s1_q;
    show_s2_d    = show_s1_q;
    // S3: glyph bit select with reverse video
    text_on_d    = in_win_s2_q && show_s2_q;
    text_bit_d   = in_win_s2_q ? (font_word[3'd7 - bit_idx_s2_q] ^ hl_s2_q) : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      char_xy_q    <= 8'h00;
      in_win_s1_q  <= 1'b0;
      gly_row_s1_q <= 4'd0;
      bit_idx_s1_q <= 3'd0;
      hl_s1_q      <= 1'b0;
      show_s1_q    <= 1'b0;
      font_addr_q  <= 11'd0;
      in_win_s2_q  <= 1'b0;
      bit_idx_s2_q <= 3'd0;
      hl_s2_q      <= 1'b0;
      show_s2_q    <= 1'b0;
      text_on_q    <= 1'b0;
      text_bit_q   <= 1'b0;
    end else begin
      char_xy_q    <= char_xy_d;
      in_win_s1_q  <= in_win_s1_d;
      gly_row_s1_q <= gly_row_s1_d;
      bit_idx_s1_q <= bit_idx_s1_d;
      hl_s1_q      <= hl_s1_d;
      show_s1_q    <= show_s1_d;
      font_addr_q  <= font_addr_d;
      in_win_s2_q  <= in_win_s2_d;
      bit_idx_s2_q <= bit_idx_s2_d;
      hl_s2_q      <= hl_s2_d;
      show_s2_q    <= show_s2_d;
      text_on_q    <= text_on_d;
      text_bit_q   <= text_bit_d;
    end
  end

  assign char_xy   = char_xy_q;
  assign font_addr = font_addr_q;
  assign text_on   = text_on_q;
  assign text_bit  = text_bit_q;

endmodule

// File: rtl/mode_menu_text_ctrl.sv
// Mode-select menu: cursor/blink/selection FSM that reports the chosen game
// mode, driving the text overlay pipeline with highlight and show sideband.
module mode_menu_text_ctrl
  import pong_pkg::*;
#(
  parameter int TEXT_X0    = 256,
  parameter int TEXT_Y0    = 208,
  parameter int NUM_MODES  = 3,
  parameter int BLINK_BITS = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        menu_active,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_sel,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_word,
  output logic        text_on,
  output logic        text_bit,
  output logic [1:0]  mode,
  output logic        mode_valid
);

  localparam logic [1:0] LAST_MODE = 2'(NUM_MODES - 1);

  menu_state_e           state_q, state_d;
  logic [1:0]            cursor_q, cursor_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [1:0]            mode_q, mode_d;
  logic                  mode_valid_q, mode_valid_d;

  logic [3:0] win_row;
  logic       show, hl;

  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    blink_d      = blink_q;
    mode_d       = mode_q;
    mode_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (menu_active) begin
          state_d  = ST_MENU;
          cursor_d = 2'd0;
          blink_d  = '0;
        end
      end
      ST_MENU: begin
        blink_d = blink_q + BLINK_BITS'(1);
        // Leaving the menu abandons the selection; select beats up/down.
        if (!menu_active) begin
          state_d = ST_IDLE;
        end else if (btn_sel) begin
          state_d = ST_CONFIRM;
        end else if (btn_down && !btn_up) begin
          cursor_d = (cursor_q == LAST_MODE) ? 2'd0 : cursor_q + 2'd1;
        end else if (btn_up && !btn_down) begin
          cursor_d = (cursor_q == 2'd0) ? LAST_MODE : cursor_q - 2'd1;
        end
      end
      ST_CONFIRM: begin
        mode_d       = cursor_q;
        mode_valid_d = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (!menu_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cursor_q     <= 2'd0;
      blink_q      <= '0;
      mode_q       <= 2'd0;
      mode_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      blink_q      <= blink_d;
      mode_q       <= mode_d;
      mode_valid_q <= mode_valid_d;
    end
  end

  // Option rows start below the title row, hence the +1.
  always_comb begin
    show = (state_q == ST_MENU) || (state_q == ST_CONFIRM);
    hl   = (win_row == ({2'b00, cursor_q} + 4'd1)) && blink_q[BLINK_BITS-1] &&
           (state_q == ST_MENU);
  end

  text_scan_pipe #(
    .TEXT_X0(TEXT_X0),
    .TEXT_Y0(TEXT_Y0)
  ) u_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .video_on (video_on),
    .show     (show),
    .hl       (hl),
    .char_code(char_code),
    .font_word(font_word),
    .win_row  (win_row),
    .char_xy  (char_xy),
    .font_addr(font_addr),
    .text_on  (text_on),
    .text_bit (text_bit)
  );

  assign mode       = mode_q;
  assign mode_valid = mode_valid_q;

endmodule

// File: tb/tb_mode_menu_text_ctrl.sv
// Directed bench for the mode-select menu: window decode, pipeline latency,
// cursor wrapping, blink highlight, selection pulse and async reset.
module tb_mode_menu_text_ctrl;
  import pong_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, menu_active, btn_up, btn_down, btn_sel;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_word;
  logic        text_on, text_bit;
  logic [1:0]  mode;
  logic        mode_valid;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mode_menu_text_ctrl #(
    .TEXT_X0(256), .TEXT_Y0(208), .NUM_MODES(3), .BLINK_BITS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .menu_active(menu_active), .btn_up(btn_up),
    .btn_down(btn_down), .btn_sel(btn_sel), .char_xy(char_xy),
    .char_code(char_code), .font_addr(font_addr), .font_word(font_word),
    .text_on(text_on), .text_bit(text_bit), .mode(mode), .mode_valid(mode_valid)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pix(input int x, input int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
  endtask

  task automatic pulse(input logic up, input logic dn, input logic sel);
    btn_up = up; btn_down = dn; btn_sel = sel;
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
  endtask

  // Holds the current pixel, flushes the pipeline, then counts inverted
  // glyph bits (font bit is 1 at bit_idx 0) over one full blink period.
  task automatic count_inv(input int x, input int y, output int inv);
    set_pix(x, y);
    tick(4);
    inv = 0;
    for (int i = 0; i < 16; i++) begin
      if (text_on && !text_bit) inv++;
      tick();
    end
  endtask

  int ons, inv, pulses;

  initial begin
    reset_n = 1'b0; video_on = 1'b0; menu_active = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    char_code = 7'h4D; font_word = 8'h80;
    set_pix(0, 0);
    tick(2);
    check_val("rst_char_xy", char_xy, 0);
    check_val("rst_font_addr", font_addr, 0);
    check_val("rst_text_on", text_on, 0);
    check_val("rst_text_bit", text_bit, 0);
    check_val("rst_mode", mode, 0);
    check_val("rst_mode_valid", mode_valid, 0);
    reset_n = 1'b1;
    video_on = 1'b1;

    // Menu not requested: a frame sweep over the window never lights text.
    ons = 0;
    for (int y = 200; y < 280; y += 4)
      for (int x = 240; x < 400; x += 4) begin
        set_pix(x, y);
        tick();
        if (text_on) ons++;
      end
    check_val("idle_sweep_text_on", ons, 0);

    menu_active = 1'b1;
    tick();
    check_val("enter_menu_state", dut.state_q, ST_MENU);

    set_pix(256, 208);
    tick();
    check_val("origin_char_xy", char_xy, 8'h00);
    tick();
    check_val("origin_font_addr", font_addr, 11'h4D0);
    tick();
    check_val("origin_text_on", text_on, 1);
    check_val("origin_text_bit", text_bit, 1);

    set_pix(257, 208);
    tick(3);
    check_val("bit6_text_bit", text_bit, 0);

    set_pix(383, 271);
    tick();
    check_val("corner_char_xy", char_xy, 8'h3F);
    tick(2);
    check_val("corner_text_on", text_on, 1);

    set_pix(384, 208);
    tick(3);
    check_val("right_edge_text_on", text_on, 0);
    check_val("right_edge_char_xy", char_xy, 8'h00);
    set_pix(300, 272);
    tick(3);
    check_val("bottom_edge_text_on", text_on, 0);
    set_pix(255, 220);
    tick(3);
    check_val("left_edge_text_on", text_on, 0);
    set_pix(300, 240);
    video_on = 1'b0;
    tick(3);
    check_val("video_off_text_on", text_on, 0);
    video_on = 1'b1;

    // Highlight: cursor 0 maps to text row 1 only.
    check_val("cursor_start", dut.cursor_q, 0);
    count_inv(256, 224, inv);
    check_val("hl_row1_inverted", inv, 8);
    count_inv(256, 208, inv);
    check_val("hl_row0_inverted", inv, 0);
    count_inv(256, 240, inv);
    check_val("hl_row2_inverted", inv, 0);

    pulse(1'b1, 1'b0, 1'b0);
    check_val("up_wrap_cursor", dut.cursor_q, 2);
    pulse(1'b0, 1'b1, 1'b0);
    check_val("down_wrap_cursor", dut.cursor_q, 0);
    pulse(1'b0, 1'b1, 1'b0);
    check_val("down_cursor", dut.cursor_q, 1);
    pulse(1'b1, 1'b1, 1'b0);
    check_val("up_down_cursor", dut.cursor_q, 1);
    count_inv(256, 240, inv);
    check_val("hl_row2_cursor1", inv, 8);

    pulse(1'b0, 1'b1, 1'b1);
    check_val("sel_state", dut.state_q, ST_CONFIRM);
    check_val("sel_cursor_kept", dut.cursor_q, 1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mode_valid) pulses++;
    end
    check_val("mode_valid_pulses", pulses, 1);
    check_val("mode_after_sel", mode, 1);
    check_val("done_state", dut.state_q, ST_DONE);

    set_pix(256, 224);
    tick(3);
    check_val("done_text_on", text_on, 0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mode_valid) pulses++;
    end
    check_val("done_btn_pulses", pulses, 0);
    check_val("done_btn_cursor", dut.cursor_q, 1);
    check_val("done_btn_state", dut.state_q, ST_DONE);

    menu_active = 1'b0;
    tick();
    check_val("exit_idle_state", dut.state_q, ST_IDLE);
    menu_active = 1'b1;
    tick();
    check_val("reenter_cursor", dut.cursor_q, 0);

    // Abandon the menu mid-selection: mode must not change.
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    menu_active = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mode_valid) pulses++;
    end
    check_val("abandon_pulses", pulses, 0);
    check_val("abandon_mode", mode, 1);
    check_val("abandon_state", dut.state_q, ST_IDLE);

    menu_active = 1'b1;
    set_pix(256, 208);
    tick(4);
    check_val("pre_reset_text_on", text_on, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_state", dut.state_q, ST_IDLE);
    check_val("async_rst_text_on", text_on, 0);
    check_val("async_rst_char_xy", char_xy, 0);
    check_val("async_rst_font_addr", font_addr, 0);
    check_val("async_rst_mode", mode, 0);
    tick();
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
